pc_sequencer: RTL and testbench

- Parametrised program-sequencing unit for the next-generation miniMips core.
- Generalises single-cycle PC update (+1 or relative jump on lt_flag) into a controlled sequencer with:
  - start/done run-control FSM;
  - signed relative branches and absolute jumps;
  - call/return stack of configurable depth;
  - halt-instruction detection, stall support, error reporting.
- Sits between instruction memory (drives its address) and control/ALU (consumes their branch decisions).

---
 rtl/pc_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program sequencer: drives the instruction-memory address, with start/done run control, branches, calls and returns.
// Optional RUN-cycle counter is built only when PC_SEQUENCER_CYCLE_COUNT_EN is defined.
module pc_sequencer #(
   parameter int unsigned          PC_W        = 8,
   parameter int unsigned          INSTR_W     = 9,
   parameter logic [INSTR_W-1:0]   HALT_INSTR  = 9'h1FF,
   parameter logic [PC_W-1:0]      START_PC    = {PC_W{1'b0}},
   parameter int unsigned          STACK_DEPTH = 4,
   parameter int unsigned          CNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   input  logic [INSTR_W-1:0] instr,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_off,
   input  logic               jump_abs,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               call,
   input  logic               ret,
   output logic [PC_W-1:0]    pc,
   output logic               running,
   output logic               done,
   output logic               err,
   output logic [CNT_W-1:0]   cycle_count
);

   localparam int SP_W = $clog2(STACK_DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              err_q, err_d;
   logic              running_q, done_q;
   logic [PC_W-1:0]   stack_q [STACK_DEPTH];
   logic [PC_W-1:0]   stack_top;
   logic [PC_W-1:0]   pc_inc;
   logic              stack_empty, stack_full;
   logic              do_push;

   assign pc_inc      = pc_q + PC_W'(1'b1);
   assign stack_empty = (sp_q == {SP_W{1'b0}});
   assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));

   // Read the most recently pushed return address (entry below the stack pointer).
   always_comb begin
      stack_top = {PC_W{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (sp_q == SP_W'(i + 1)) begin
            stack_top = stack_q[i];
         end else begin
            stack_top = stack_top;
         end
      end
   end

   // Next-state decode: run control plus the RUN-state control-flow priority chain.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      err_d   = err_q;
      do_push = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_RUN;
               pc_d    = START_PC;
               sp_d    = {SP_W{1'b0}};
               err_d   = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_RUN: begin
            if (stall) begin
               state_d = S_RUN;
            end else if (instr == HALT_INSTR) begin
               state_d = S_HALT;
            end else if (ret) begin
               // ret outranks a simultaneous call; the call is simply dropped.
               if (stack_empty) begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end else begin
                  pc_d = stack_top;
                  sp_d = sp_q - SP_W'(1'b1);
               end
            end else if (call) begin
               if (stack_full) begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end else begin
                  do_push = 1'b1;
                  sp_d    = sp_q + SP_W'(1'b1);
                  pc_d    = jump_target;
               end
            end else if (jump_abs) begin
               pc_d = jump_target;
            end else if (branch_taken) begin
               pc_d = pc_q + branch_off;
            end else begin
               pc_d = pc_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM and output registers; running/done are decoded from the next state so they flip on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= START_PC;
         sp_q      <= {SP_W{1'b0}};
         err_q     <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         sp_q      <= sp_d;
         err_q     <= err_d;
         running_q <= (state_d == S_RUN);
         done_q    <= (state_d == S_HALT);
      end
   end

   // Return-stack storage; contents are qualified by the stack pointer so no reset is needed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (do_push && (sp_q == SP_W'(i))) begin
            stack_q[i] <= pc_inc;
         end else begin
            stack_q[i] <= stack_q[i];
         end
      end
   end

`ifdef PC_SEQUENCER_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of RUN-state edges, stalled or not; cleared by start.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_RUN) begin
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
         end else begin
            cnt_d = cnt_q;
         end
      end else if (start) begin
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Cycle counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cycle_count = cnt_q;
`else
   assign cycle_count = {CNT_W{1'b0}};
`endif

   assign pc      = pc_q;
   assign running = running_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table from the test plan, then randomized traffic against a queue-based model.
// Cycle-count expectations follow PC_SEQUENCER_CYCLE_COUNT_EN.
module tb_pc_sequencer;

   localparam int   DEPTH   = 2;
   localparam int   CW      = 6;
   localparam int   CNT_MAX = (1 << CW) - 1;
`ifdef PC_SEQUENCER_CYCLE_COUNT_EN
   localparam bit   CNT_EN  = 1'b1;
`else
   localparam bit   CNT_EN  = 1'b0;
`endif
   localparam logic       N   = 1'b0;
   localparam logic       Y   = 1'b1;
   localparam logic [8:0] NOP = 9'h000;
   localparam logic [8:0] HI  = 9'h1FF;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

   logic          clk;
   logic          rst_n, start, stall, branch_taken, jump_abs, call, ret;
   logic [8:0]    instr;
   logic [7:0]    branch_off, jump_target;
   logic [7:0]    pc;
   logic          running, done, err;
   logic [CW-1:0] cycle_count;

   int total = 0;
   int bad   = 0;

   int m_state = M_IDLE;
   int m_pc    = 0;
   int m_cnt   = 0;
   bit m_err   = 1'b0;
   int m_stack[$];

   typedef struct {
      logic       r, s, st;
      logic [8:0] ins;
      logic       br;
      logic [7:0] off;
      logic       jmp;
      logic [7:0] tgt;
      logic       cl, rt;
      logic [7:0] e_pc;
      logic       e_run, e_done, e_err;
   } vec_t;

   vec_t vecs[$];

   pc_sequencer #(
      .PC_W(8), .INSTR_W(9), .HALT_INSTR(9'h1FF), .START_PC(8'h00),
      .STACK_DEPTH(DEPTH), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .instr(instr),
      .branch_taken(branch_taken), .branch_off(branch_off), .jump_abs(jump_abs),
      .jump_target(jump_target), .call(call), .ret(ret), .pc(pc), .running(running),
      .done(done), .err(err), .cycle_count(cycle_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic r, s, st, input logic [8:0] ins, input logic br,
                               input logic [7:0] off, input logic jmp, input logic [7:0] tgt,
                               input logic cl, rt, input logic [7:0] e_pc, input logic e_run, e_done, e_err);
      vec_t v;
      v.r = r; v.s = s; v.st = st; v.ins = ins; v.br = br; v.off = off; v.jmp = jmp;
      v.tgt = tgt; v.cl = cl; v.rt = rt; v.e_pc = e_pc; v.e_run = e_run; v.e_done = e_done; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: one rising edge with the currently driven inputs.
   task automatic model_step();
      if (!rst_n) begin
         m_state = M_IDLE; m_pc = 0; m_err = 1'b0; m_cnt = 0; m_stack.delete();
      end else if (m_state != M_RUN) begin
         if (start) begin
            m_state = M_RUN; m_pc = 0; m_err = 1'b0; m_cnt = 0; m_stack.delete();
         end
      end else begin
         if (CNT_EN && m_cnt < CNT_MAX) m_cnt++;
         if (!stall) begin
            if (instr == HI) begin
               m_state = M_HALT;
            end else if (ret) begin
               if (m_stack.size() == 0) begin
                  m_err = 1'b1; m_state = M_HALT;
               end else begin
                  m_pc = m_stack.pop_back();
               end
            end else if (call) begin
               if (m_stack.size() >= DEPTH) begin
                  m_err = 1'b1; m_state = M_HALT;
               end else begin
                  m_stack.push_back((m_pc + 1) % 256);
                  m_pc = int'(jump_target);
               end
            end else if (jump_abs) begin
               m_pc = int'(jump_target);
            end else if (branch_taken) begin
               m_pc = (m_pc + int'($signed(branch_off))) & 255;
            end else begin
               m_pc = (m_pc + 1) % 256;
            end
         end
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n = v.r; start = v.s; stall = v.st; instr = v.ins; branch_taken = v.br;
      branch_off = v.off; jump_abs = v.jmp; jump_target = v.tgt; call = v.cl; ret = v.rt;
   endtask

   task automatic edge_and_model();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   initial begin
      vec_t v;
      v = mk(N,N,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,N,N,N);
      drive(v);

      // Count up and halt.
      vecs.push_back(mk(N,N,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,N,N,N));
      vecs.push_back(mk(Y,Y,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h00,N,N, 8'h01,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h00,N,N, 8'h02,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h00,N,N, 8'h03,Y,N,N));
      vecs.push_back(mk(Y,N,N,HI ,N,8'h00,N,8'h00,N,N, 8'h03,N,Y,N));
      vecs.push_back(mk(Y,N,Y,NOP,Y,8'hFC,Y,8'h55,Y,Y, 8'h03,N,Y,N));
      // Negative branch, wrap, start ignored in RUN, nested call/ret, overflow.
      vecs.push_back(mk(Y,Y,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,Y,8'h10,N,N, 8'h10,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,Y,8'hFC,N,8'h00,N,N, 8'h0C,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,Y,8'hFF,N,N, 8'hFF,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,Y,N,N));
      vecs.push_back(mk(Y,Y,N,NOP,N,8'h00,N,8'h00,N,N, 8'h01,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,Y,8'h05,N,N, 8'h05,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h40,Y,N, 8'h40,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h80,Y,N, 8'h80,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h00,N,Y, 8'h41,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h00,N,Y, 8'h06,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h40,Y,N, 8'h40,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h80,Y,N, 8'h80,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h90,Y,N, 8'h80,N,Y,Y));
      // call+ret priority, underflow, restart clears err.
      vecs.push_back(mk(Y,Y,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,Y,8'h20,N,N, 8'h20,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h30,Y,N, 8'h30,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h50,Y,Y, 8'h21,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h00,N,Y, 8'h21,N,Y,Y));
      vecs.push_back(mk(Y,Y,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,Y,N,N));
      // Halt under stall is deferred.
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,Y,8'h07,N,N, 8'h07,Y,N,N));
      vecs.push_back(mk(Y,N,Y,HI ,N,8'h00,N,8'h00,N,N, 8'h07,Y,N,N));
      vecs.push_back(mk(Y,N,Y,HI ,N,8'h00,N,8'h00,N,N, 8'h07,Y,N,N));
      vecs.push_back(mk(Y,N,Y,HI ,N,8'h00,N,8'h00,N,N, 8'h07,Y,N,N));
      vecs.push_back(mk(Y,N,N,HI ,N,8'h00,N,8'h00,N,N, 8'h07,N,Y,N));
      // Reset mid-RUN dominates call and start.
      vecs.push_back(mk(Y,Y,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h10,Y,N, 8'h10,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,Y,8'h22,N,N, 8'h22,Y,N,N));
      vecs.push_back(mk(N,N,N,NOP,N,8'h00,N,8'h40,Y,N, 8'h00,N,N,N));
      vecs.push_back(mk(N,Y,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,N,N,N));
      vecs.push_back(mk(Y,Y,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,Y,N,N));
      vecs.push_back(mk(Y,N,N,NOP,N,8'h00,N,8'h00,N,Y, 8'h00,N,Y,Y));

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         edge_and_model();
         chk($sformatf("v%0d.pc", i),      32'(pc),      32'(vecs[i].e_pc));
         chk($sformatf("v%0d.running", i), 32'(running), 32'(vecs[i].e_run));
         chk($sformatf("v%0d.done", i),    32'(done),    32'(vecs[i].e_done));
         chk($sformatf("v%0d.err", i),     32'(err),     32'(vecs[i].e_err));
         chk($sformatf("v%0d.cycles", i),  32'(cycle_count), 32'(m_cnt));
      end

      // Long stall run to reach counter saturation.
      v = mk(Y,Y,N,NOP,N,8'h00,N,8'h00,N,N, 8'h00,N,N,N);
      drive(v);
      edge_and_model();
      stall = 1'b1; start = 1'b0;
      for (int i = 0; i < CNT_MAX + 5; i++) edge_and_model();
      chk("sat.cycles", 32'(cycle_count), 32'(m_cnt));
      chk("sat.pc",     32'(pc),          32'(m_pc));

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst_n        = ($urandom_range(99) != 0);
         start        = ($urandom_range(19) == 0);
         stall        = ($urandom_range(4) == 0);
         instr        = ($urandom_range(15) == 0) ? HI : 9'($urandom);
         branch_taken = ($urandom_range(2) == 0);
         branch_off   = 8'($urandom);
         jump_abs     = ($urandom_range(5) == 0);
         jump_target  = 8'($urandom);
         call         = ($urandom_range(4) == 0);
         ret          = ($urandom_range(4) == 0);
         edge_and_model();
         chk("rnd.pc",      32'(pc),          32'(m_pc));
         chk("rnd.running", 32'(running),     32'(m_state == M_RUN));
         chk("rnd.done",    32'(done),        32'(m_state == M_HALT));
         chk("rnd.err",     32'(err),         32'(m_err));
         chk("rnd.cycles",  32'(cycle_count), 32'(m_cnt));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
